// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// 8N1 UART receiver on a shared 16x oversampled baud tick: mid-bit sampling,
// false-start rejection, 1-clk valid / framing-error strobes.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 baud_tick_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] MID_TICK  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e               state_q;
  logic [CW-1:0]        tick_cnt_q;
  logic [BW-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shift_reg_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 rx_meta_q;
  logic                 rx_s_q;
  logic                 rx_prev_q;

  // Synchronizer and edge-detect flops reset high so an idle line never looks like a start edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_reg_q <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
    end else begin
      rx_meta_q   <= rx_i;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tick_cnt_q <= '0;
          if (rx_prev_q && !rx_s_q) begin
            state_q <= START;
          end
        end
        START: begin
          if (baud_tick_i) begin
            if (tick_cnt_q == MID_TICK) begin
              tick_cnt_q <= '0;
              bit_idx_q  <= '0;
              state_q    <= rx_s_q ? IDLE : DATA;
            end else begin
              tick_cnt_q <= tick_cnt_q + CW'(1);
            end
          end
        end
        // Counting a full bit period from the start mid-point keeps every sample mid-bit.
        DATA: begin
          if (baud_tick_i) begin
            if (tick_cnt_q == LAST_TICK) begin
              tick_cnt_q             <= '0;
              shift_reg_q[bit_idx_q] <= rx_s_q;
              if (bit_idx_q == LAST_BIT) begin
                state_q <= STOP;
              end else begin
                bit_idx_q <= bit_idx_q + BW'(1);
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + CW'(1);
            end
          end
        end
        STOP: begin
          if (baud_tick_i) begin
            if (tick_cnt_q == LAST_TICK) begin
              tick_cnt_q <= '0;
              state_q    <= IDLE;
              if (rx_s_q) begin
                rx_data_q  <= shift_reg_q;
                rx_valid_q <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          tick_cnt_q <= '0;
        end
      endcase
    end
  end

  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx: table vectors, directed corner sequences,
// and randomized frames checked against a frame-level reference model.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] expQ[$];
  logic [8:0] obsQ[$];
  logic [7:0] lastGood = 8'h00;
  bit         bothSeen = 1'b0;

  typedef struct {
    logic [7:0] data;
    bit         stopBit;
    int         skew;
    bit         expValid;
    bit         expErr;
    logic [7:0] expHeld;
  } vec_t;

  vec_t vecs[8];

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .baud_tick_i(baud_tick),
    .rx_i       (rx),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .frame_err_o(frame_err),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  // Observed output events: {1'b0, data} for a valid byte, 9'h100 for a framing error.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) obsQ.push_back({1'b0, rx_data});
      if (frame_err) obsQ.push_back(9'h100);
      if (rx_valid && frame_err) bothSeen = 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic waitClks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // A frame is start bit, 8 data bits LSB first, stop bit; skew stretches or shrinks the start bit.
  task automatic applyStimulus(input logic [7:0] data, input bit stopBit, input int skew);
    rx = 1'b0;
    waitClks(BIT_CLKS + skew * 4);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      waitClks(BIT_CLKS);
    end
    rx = stopBit;
    waitClks(BIT_CLKS);
  endtask

  task automatic expectFrame(input logic [7:0] data, input bit stopBit);
    if (stopBit) begin
      expQ.push_back({1'b0, data});
      lastGood = data;
    end else begin
      expQ.push_back(9'h100);
    end
  endtask

  task automatic checkOutput(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkValue($sformatf("%s idle", name), 32'(n >= 3000), 32'(0));
    waitClks(4);
    checkValue($sformatf("%s count", name), 32'(obsQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      checkValue($sformatf("%s ev%0d", name, i), 32'(obsQ[i]), 32'(expQ[i]));
    end
    checkValue($sformatf("%s held", name), 32'(rx_data), 32'(lastGood));
    checkValue($sformatf("%s quiet", name), 32'({rx_valid, frame_err}), 32'(0));
    obsQ.delete();
    expQ.delete();
  endtask

  initial begin
    logic [7:0] d;
    bit         sb;
    int         sk;

    vecs[0] = '{8'hA5, 1'b1,  0, 1'b1, 1'b0, 8'hA5};
    vecs[1] = '{8'h96, 1'b1, -5, 1'b1, 1'b0, 8'h96};
    vecs[2] = '{8'h96, 1'b1, -3, 1'b1, 1'b0, 8'h96};
    vecs[3] = '{8'h96, 1'b1, -1, 1'b1, 1'b0, 8'h96};
    vecs[4] = '{8'h96, 1'b1,  1, 1'b1, 1'b0, 8'h96};
    vecs[5] = '{8'h96, 1'b1,  3, 1'b1, 1'b0, 8'h96};
    vecs[6] = '{8'h96, 1'b1,  5, 1'b1, 1'b0, 8'h96};
    vecs[7] = '{8'hC3, 1'b0,  0, 1'b0, 1'b1, 8'h96};

    rst = 1'b1;
    rx  = 1'b1;
    waitClks(5);
    rst = 1'b0;
    waitClks(1);
    checkValue("reset rx_data", 32'(rx_data), 32'(0));
    checkValue("reset rx_valid", 32'(rx_valid), 32'(0));
    checkValue("reset frame_err", 32'(frame_err), 32'(0));
    checkValue("reset busy", 32'(busy), 32'(0));

    for (int i = 0; i < 8; i++) begin
      rx = 1'b1;
      waitClks(20);
      applyStimulus(vecs[i].data, vecs[i].stopBit, vecs[i].skew);
      rx = 1'b1;
      if (vecs[i].expValid) expQ.push_back({1'b0, vecs[i].data});
      if (vecs[i].expErr) expQ.push_back(9'h100);
      lastGood = vecs[i].expHeld;
      checkOutput($sformatf("vec%0d", i));
    end

    // Short low glitch must be rejected at the start-bit mid-point.
    rx = 1'b1;
    waitClks(20);
    rx = 1'b0;
    waitClks(10);
    checkValue("glitch busy", 32'(busy), 32'(1));
    waitClks(6);
    rx = 1'b1;
    waitClks(200);
    checkValue("glitch back idle", 32'(busy), 32'(0));
    checkOutput("glitch");

    rx = 1'b1;
    waitClks(20);
    applyStimulus(8'h3C, 1'b0, 0);
    expectFrame(8'h3C, 1'b0);
    waitClks(3 * BIT_CLKS);
    checkValue("hold low busy", 32'(busy), 32'(0));
    rx = 1'b1;
    waitClks(BIT_CLKS);
    checkOutput("stop low");

    rx = 1'b1;
    waitClks(20);
    applyStimulus(8'h00, 1'b1, 0);
    applyStimulus(8'hFF, 1'b1, 0);
    expectFrame(8'h00, 1'b1);
    expectFrame(8'hFF, 1'b1);
    rx = 1'b1;
    checkOutput("b2b");

    // Reset during data bit 3 of a 0x5A frame.
    rx = 1'b1;
    waitClks(20);
    rx = 1'b0;
    waitClks(BIT_CLKS);
    d = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      waitClks(BIT_CLKS);
    end
    rx = d[3];
    waitClks(20);
    checkValue("rst busy before", 32'(busy), 32'(1));
    rst = 1'b1;
    waitClks(1);
    checkValue("rst rx_data", 32'(rx_data), 32'(0));
    checkValue("rst rx_valid", 32'(rx_valid), 32'(0));
    checkValue("rst frame_err", 32'(frame_err), 32'(0));
    checkValue("rst busy", 32'(busy), 32'(0));
    rst = 1'b0;
    rx = 1'b1;
    lastGood = 8'h00;
    waitClks(12 * BIT_CLKS);
    checkOutput("after rst");
    applyStimulus(8'h5A, 1'b1, 0);
    expectFrame(8'h5A, 1'b1);
    rx = 1'b1;
    checkOutput("post rst frame");

    for (int f = 0; f < 24; f++) begin
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      sk = int'($urandom_range(0, 6)) - 3;
      rx = 1'b1;
      waitClks(int'($urandom_range(8, 80)));
      applyStimulus(d, sb, sk);
      expectFrame(d, sb);
      if (f % 6 == 5) begin
        rx = 1'b1;
        checkOutput($sformatf("rand%0d", f));
      end
    end

    checkValue("no overlap", 32'(bothSeen), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
